// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock behind a
// start/done handshake so the pipeline controller can stall while it runs.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic             r_busy;
    logic             r_done;
    logic             r_div_by_zero;

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;

    // Bit WIDTH of the trial difference is the borrow: set means restore.
    assign w_shifted = {r_rem, r_q[WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, r_divisor};

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_divisor     <= '0;
            r_q           <= '0;
            r_rem         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            r_q           <= '1;
                            r_rem         <= dividend;
                            r_div_by_zero <= 1'b1;
                            r_done        <= 1'b1;
                            r_state       <= DONE;
                        end else begin
                            r_divisor     <= divisor;
                            r_q           <= dividend;
                            r_rem         <= '0;
                            r_count       <= '0;
                            r_div_by_zero <= 1'b0;
                            r_busy        <= 1'b1;
                            r_state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shifted[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_ITER) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_q;
    assign remainder   = r_rem;
    assign div_by_zero = r_div_by_zero;

endmodule
